fighter_state_fsm: RTL and testbench

Parametrised per-player fighter state machine that turns debounced pad inputs and collision results into the character's action state. It is the successor of the single-player sprite FSM.
- New behaviour: frame-tick gating, stuns that interrupt any state, stun length chosen by the attack received, rising-edge attack detection, and a recovery input buffer.
- Sits between the input debouncer and the sprite renderer / collision checker; one instance per player.

---
 rtl/fighter_pkg.sv | 43 ++++
 rtl/fighter_input_buffer.sv | 74 +++++++
 rtl/fighter_state_fsm.sv | 167 ++++++++++++++++
 tb/tb_fighter_state_fsm.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared state codes, default frame lengths and stun-length helper
// Purpose: common definitions for the per-player fighter state machine.
//   fighter_state_t : 4-bit action state codes (0..10)
//   DEF_*           : default frame-length constants
//   stun_len()      : stun length from (hit/block, attacker used directional)
package fighter_pkg;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_BACKWARD     = 4'd1,
        ST_FORWARD      = 4'd2,
        ST_ATK_START    = 4'd3,
        ST_ATK_ACTIVE   = 4'd4,
        ST_ATK_RECOVERY = 4'd5,
        ST_DIR_START    = 4'd6,
        ST_DIR_ACTIVE   = 4'd7,
        ST_DIR_RECOVERY = 4'd8,
        ST_HITSTUN      = 4'd9,
        ST_BLOCKSTUN    = 4'd10
    } fighter_state_t;

    localparam int DEF_CNT_W            = 6;
    localparam int DEF_ATK_START        = 5;
    localparam int DEF_ATK_ACTIVE       = 2;
    localparam int DEF_ATK_RECOVERY     = 16;
    localparam int DEF_DIR_START        = 4;
    localparam int DEF_DIR_ACTIVE       = 3;
    localparam int DEF_DIR_RECOVERY     = 15;
    localparam int DEF_HITSTUN_OFFSET   = 1;
    localparam int DEF_BLOCKSTUN_OFFSET = 3;
    localparam int DEF_BUF_FRAMES       = 3;

    // Stun length is the attacker's recovery minus a hit- or block-specific
    // offset, so the attacker's frame advantage is fixed by the offsets.
    function automatic int stun_len(input logic is_block, input logic dir_src,
                                    input int atk_rec, input int dir_rec,
                                    input int hit_off, input int blk_off);
        int rec;
        rec = dir_src ? dir_rec : atk_rec;
        return rec - (is_block ? blk_off : hit_off);
    endfunction

endpackage

// File: rtl/fighter_input_buffer.sv
// rtl/fighter_input_buffer.sv - attack press edge detector and recovery input buffer
// Purpose: detects rising edges of attack (sampled on frame ticks only) and holds
// one buffered press issued near the end of a recovery state.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   frame_tick          update strobe; all registers hold without it
//   attack, left, right debounced pad levels
//   in_recovery         FSM is in a recovery state
//   frame_counter       frames elapsed in the current state
//   rec_len             length of the current recovery state in frames
//   clear               drop the slot on this tick (stun entry, recovery exit)
//   press               rising edge of attack relative to the last tick
//   slot_valid          slot occupied (registered)
//   take_valid/take_dir slot contents including a press stored on this tick
import fighter_pkg::*;

module fighter_input_buffer #(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int BUF_FRAMES = DEF_BUF_FRAMES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             attack,
    input  logic             left,
    input  logic             right,
    input  logic             in_recovery,
    input  logic [CNT_W-1:0] frame_counter,
    input  logic [CNT_W:0]   rec_len,
    input  logic             clear,
    output logic             press,
    output logic             slot_valid,
    output logic             take_valid,
    output logic             take_dir
);

    localparam int WW = CNT_W + 2;

    logic attack_q;
    logic slot_dir;
    logic in_window;
    logic store;

    assign press = attack & ~attack_q;

    // counter >= len - BUF_FRAMES, rearranged to avoid an underflowing subtract
    assign in_window = (BUF_FRAMES > 0) &&
                       (({2'b00, frame_counter} + WW'(BUF_FRAMES)) >= {1'b0, rec_len});

    // first press in the window wins
    assign store = frame_tick & in_recovery & press & in_window & ~slot_valid;

    // a press landing on the exit tick itself still counts
    assign take_valid = slot_valid | store;
    assign take_dir   = slot_valid ? slot_dir : (left ^ right);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            attack_q   <= 1'b0;
            slot_valid <= 1'b0;
            slot_dir   <= 1'b0;
        end else if (frame_tick) begin
            attack_q <= attack;
            if (clear) begin
                slot_valid <= 1'b0;
                slot_dir   <= 1'b0;
            end else if (store) begin
                slot_valid <= 1'b1;
                slot_dir   <= left ^ right;
            end
        end
    end

endmodule

// File: rtl/fighter_state_fsm.sv
// rtl/fighter_state_fsm.sv - per-player fighter action state machine
// Purpose: turns debounced pad levels and collision results into the action
// state, advancing only on frame ticks.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   frame_tick                 one-cycle strobe per video frame
//   left, right, attack        debounced pad levels
//   got_hit, got_blocked       tick-aligned collision results
//   src_dir                    attacker used a directional attack
//   state                      current state code
//   frame_counter              frames elapsed in the current state
//   move_flag                  BACKWARD or FORWARD
//   attack_flag                start/active of either attack
//   directional_attack_flag    DIR_START or DIR_ACTIVE
//   hitbox_active              ATK_ACTIVE or DIR_ACTIVE
//   stunned                    HITSTUN or BLOCKSTUN
//   buffered                   recovery buffer slot occupied
import fighter_pkg::*;

module fighter_state_fsm #(
    parameter int CNT_W            = DEF_CNT_W,
    parameter int ATK_START        = DEF_ATK_START,
    parameter int ATK_ACTIVE       = DEF_ATK_ACTIVE,
    parameter int ATK_RECOVERY     = DEF_ATK_RECOVERY,
    parameter int DIR_START        = DEF_DIR_START,
    parameter int DIR_ACTIVE       = DEF_DIR_ACTIVE,
    parameter int DIR_RECOVERY     = DEF_DIR_RECOVERY,
    parameter int HITSTUN_OFFSET   = DEF_HITSTUN_OFFSET,
    parameter int BLOCKSTUN_OFFSET = DEF_BLOCKSTUN_OFFSET,
    parameter int BUF_FRAMES       = DEF_BUF_FRAMES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             left,
    input  logic             right,
    input  logic             attack,
    input  logic             got_hit,
    input  logic             got_blocked,
    input  logic             src_dir,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] frame_counter,
    output logic             move_flag,
    output logic             attack_flag,
    output logic             directional_attack_flag,
    output logic             hitbox_active,
    output logic             stunned,
    output logic             buffered
);

    // one bit wider than the counter so a length of 2^CNT_W is representable
    localparam int LW = CNT_W + 1;

    fighter_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LW-1:0]    stun_len_q, stun_len_d;
    logic [LW-1:0]    cur_len;
    logic             phase_done;
    logic             in_recovery;
    logic             stun_in;
    logic             buf_clear;
    logic             press;
    logic             take_valid;
    logic             take_dir;

    fighter_input_buffer #(
        .CNT_W      (CNT_W),
        .BUF_FRAMES (BUF_FRAMES)
    ) u_input_buffer (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .attack        (attack),
        .left          (left),
        .right         (right),
        .in_recovery   (in_recovery),
        .frame_counter (cnt_q),
        .rec_len       (cur_len),
        .clear         (buf_clear),
        .press         (press),
        .slot_valid    (buffered),
        .take_valid    (take_valid),
        .take_dir      (take_dir)
    );

    always_comb begin
        case (state_q)
            ST_ATK_START:               cur_len = LW'(ATK_START);
            ST_ATK_ACTIVE:              cur_len = LW'(ATK_ACTIVE);
            ST_ATK_RECOVERY:            cur_len = LW'(ATK_RECOVERY);
            ST_DIR_START:               cur_len = LW'(DIR_START);
            ST_DIR_ACTIVE:              cur_len = LW'(DIR_ACTIVE);
            ST_DIR_RECOVERY:            cur_len = LW'(DIR_RECOVERY);
            ST_HITSTUN, ST_BLOCKSTUN:   cur_len = stun_len_q;
            default:                    cur_len = LW'(1);
        endcase
    end

    assign phase_done  = ({1'b0, cnt_q} == (cur_len - LW'(1)));
    assign in_recovery = (state_q == ST_ATK_RECOVERY) || (state_q == ST_DIR_RECOVERY);
    assign stun_in     = got_hit | got_blocked;
    assign buf_clear   = stun_in | (in_recovery & phase_done);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stun_len_d = stun_len_q;
        if (frame_tick) begin
            if (got_hit) begin
                state_d    = ST_HITSTUN;
                stun_len_d = LW'(stun_len(1'b0, src_dir, ATK_RECOVERY, DIR_RECOVERY,
                                          HITSTUN_OFFSET, BLOCKSTUN_OFFSET));
            end else if (got_blocked) begin
                state_d    = ST_BLOCKSTUN;
                stun_len_d = LW'(stun_len(1'b1, src_dir, ATK_RECOVERY, DIR_RECOVERY,
                                          HITSTUN_OFFSET, BLOCKSTUN_OFFSET));
            end else begin
                case (state_q)
                    ST_IDLE, ST_BACKWARD, ST_FORWARD: begin
                        // a press with both directions held falls through to movement
                        if (press && (left ^ right))          state_d = ST_DIR_START;
                        else if (press && !left && !right)    state_d = ST_ATK_START;
                        else if (left && !right)              state_d = ST_BACKWARD;
                        else if (right && !left)              state_d = ST_FORWARD;
                        else                                  state_d = ST_IDLE;
                    end
                    ST_ATK_START:  if (phase_done) state_d = ST_ATK_ACTIVE;
                    ST_ATK_ACTIVE: if (phase_done) state_d = ST_ATK_RECOVERY;
                    ST_DIR_START:  if (phase_done) state_d = ST_DIR_ACTIVE;
                    ST_DIR_ACTIVE: if (phase_done) state_d = ST_DIR_RECOVERY;
                    ST_ATK_RECOVERY, ST_DIR_RECOVERY: begin
                        if (phase_done) begin
                            if (take_valid) state_d = take_dir ? ST_DIR_START : ST_ATK_START;
                            else            state_d = ST_IDLE;
                        end
                    end
                    ST_HITSTUN, ST_BLOCKSTUN: if (phase_done) state_d = ST_IDLE;
                    default:                  state_d = ST_IDLE;
                endcase
            end
            // a stun restarts the counter even when re-entering the same stun state
            cnt_d = (stun_in || (state_d != state_q)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            stun_len_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stun_len_q <= stun_len_d;
        end
    end

    assign state                   = state_q;
    assign frame_counter           = cnt_q;
    assign move_flag               = (state_q == ST_BACKWARD) || (state_q == ST_FORWARD);
    assign attack_flag             = (state_q == ST_ATK_START) || (state_q == ST_ATK_ACTIVE) ||
                                     (state_q == ST_DIR_START) || (state_q == ST_DIR_ACTIVE);
    assign directional_attack_flag = (state_q == ST_DIR_START) || (state_q == ST_DIR_ACTIVE);
    assign hitbox_active           = (state_q == ST_ATK_ACTIVE) || (state_q == ST_DIR_ACTIVE);
    assign stunned                 = (state_q == ST_HITSTUN) || (state_q == ST_BLOCKSTUN);

endmodule

// File: tb/tb_fighter_state_fsm.sv
// tb/tb_fighter_state_fsm.sv - self-checking bench for fighter_state_fsm
module tb_fighter_state_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick, left, right, attack, got_hit, got_blocked, src_dir;
    logic [3:0] state;
    logic [5:0] frame_counter;
    logic       move_flag, attack_flag, directional_attack_flag;
    logic       hitbox_active, stunned, buffered;

    int checks = 0;
    int errors = 0;

    fighter_state_fsm dut (
        .clk                     (clk),
        .reset                   (reset),
        .frame_tick              (frame_tick),
        .left                    (left),
        .right                   (right),
        .attack                  (attack),
        .got_hit                 (got_hit),
        .got_blocked             (got_blocked),
        .src_dir                 (src_dir),
        .state                   (state),
        .frame_counter           (frame_counter),
        .move_flag               (move_flag),
        .attack_flag             (attack_flag),
        .directional_attack_flag (directional_attack_flag),
        .hitbox_active           (hitbox_active),
        .stunned                 (stunned),
        .buffered                (buffered)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model (default parameters) ----------------
    int   m_state = 0, m_cnt = 0, m_len = 0;
    logic m_aq = 1'b0, m_bv = 1'b0, m_bd = 1'b0;
    int   n_state, n_cnt, n_len, md;
    logic n_bv, n_bd, mp;

    // frames each timed phase lasts; stuns use the latched length
    function automatic int duration(input int s, input int stun);
        case (s)
            3: return 5;
            4: return 2;
            5: return 16;
            6: return 4;
            7: return 3;
            8: return 15;
            default: return stun;
        endcase
    endfunction

    always_comb begin
        n_state = m_state;
        n_len   = m_len;
        n_bv    = m_bv;
        n_bd    = m_bd;
        mp      = attack && !m_aq;
        md      = duration(m_state, m_len);
        if (got_hit) begin
            n_state = 9;
            n_len   = (src_dir ? 15 : 16) - 1;
            n_bv    = 1'b0;
        end else if (got_blocked) begin
            n_state = 10;
            n_len   = (src_dir ? 15 : 16) - 3;
            n_bv    = 1'b0;
        end else if (m_state <= 2) begin
            if (mp && (left != right))       n_state = 6;
            else if (mp && !left && !right)  n_state = 3;
            else if (left && !right)         n_state = 1;
            else if (right && !left)         n_state = 2;
            else                             n_state = 0;
        end else begin
            if ((m_state == 5 || m_state == 8) && mp && !m_bv && (m_cnt + 3 >= md)) begin
                n_bv = 1'b1;
                n_bd = left ^ right;
            end
            if (m_cnt == md - 1) begin
                if (m_state == 5 || m_state == 8) begin
                    n_state = n_bv ? (n_bd ? 6 : 3) : 0;
                    n_bv    = 1'b0;
                end else if (m_state >= 9) begin
                    n_state = 0;
                end else begin
                    n_state = m_state + 1;
                end
            end
        end
        n_cnt = (got_hit || got_blocked || n_state != m_state) ? 0 : (m_cnt + 1) % 64;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= 0; m_cnt <= 0; m_len <= 0;
            m_aq <= 1'b0; m_bv <= 1'b0; m_bd <= 1'b0;
        end else if (frame_tick) begin
            m_state <= n_state; m_cnt <= n_cnt; m_len <= n_len;
            m_aq <= attack; m_bv <= n_bv; m_bd <= n_bd;
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    logic [15:0] exp_v, act_v;
    always @(negedge clk) begin
        exp_v = {4'(m_state), 6'(m_cnt),
                 (m_state == 1 || m_state == 2),
                 (m_state == 3 || m_state == 4 || m_state == 6 || m_state == 7),
                 (m_state == 6 || m_state == 7),
                 (m_state == 4 || m_state == 7),
                 (m_state == 9 || m_state == 10),
                 m_bv};
        act_v = {state, frame_counter, move_flag, attack_flag, directional_attack_flag,
                 hitbox_active, stunned, buffered};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_cmp t=%0t actual=%h expected=%h", $time, act_v, exp_v);
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        @(negedge clk); #1;
        frame_tick  = 1'b0;
        got_hit     = 1'b0;
        got_blocked = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic settle();
        attack = 0; left = 0; right = 0; got_hit = 0; got_blocked = 0; src_dir = 0;
        do_tick();
        for (int i = 0; i < 60 && state != 4'd0; i++) do_tick();
        lit("settle_idle", int'(state), 0);
    endtask

    // neutral press at tick 0, then ticks until recovery counter reaches c
    task automatic atk_to_rec(input int c);
        attack = 1'b1;
        do_tick();
        attack = 1'b0;
        repeat (7 + c) do_tick();
        lit("rec_state", int'(state), 5);
        lit("rec_counter", int'(frame_counter), c);
    endtask

    int e, n;

    initial begin
        reset = 1'b1; frame_tick = 0; left = 0; right = 0; attack = 0;
        got_hit = 0; got_blocked = 0; src_dir = 0;
        @(negedge clk); #1;
        lit("reset_state", int'(state), 0);
        lit("reset_flags", int'({move_flag, attack_flag, directional_attack_flag,
                                 hitbox_active, stunned, buffered}), 0);
        reset = 1'b0;
        @(negedge clk); #1;

        // neutral attack: 3 x5, 4 x2, 5 x16, then IDLE
        n = 0;
        attack = 1'b1;
        for (int k = 0; k < 24; k++) begin
            do_tick();
            if (k == 0) attack = 1'b0;
            e = (k < 5) ? 3 : (k < 7) ? 4 : (k < 23) ? 5 : 0;
            lit("atk_seq", int'(state), e);
            if (hitbox_active) n++;
        end
        lit("atk_hitbox_ticks", n, 2);

        // held attack+right: one directional attack only
        settle();
        attack = 1'b1; right = 1'b1;
        for (int k = 0; k < 36; k++) begin
            do_tick();
            if (k == 0)  lit("dir_start", int'(state), 6);
            if (k == 22) lit("dir_exit_idle", int'(state), 0);
            if (k == 35) lit("held_no_retrigger", int'(state), 2);
        end
        attack = 1'b0;
        do_tick();
        attack = 1'b1;
        do_tick();
        lit("repress_dir", int'(state), 6);

        // directional hit during ATK_ACTIVE: 14 stunned ticks
        settle();
        attack = 1'b1;
        repeat (6) do_tick();
        attack = 1'b0;
        lit("in_atk_active", int'(state), 4);
        got_hit = 1'b1; src_dir = 1'b1;
        do_tick();
        lit("hitstun_entry", int'(state), 9);
        n = stunned ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            do_tick();
            if (stunned) n++;
        end
        lit("hitstun_len_dir", n, 14);
        lit("hitstun_exit", int'(state), 0);
        got_hit = 1'b1; got_blocked = 1'b1; src_dir = 1'b0;
        do_tick();
        lit("hit_over_block", int'(state), 9);

        // buffered directional press at recovery frame 13
        settle();
        atk_to_rec(13);
        attack = 1'b1; left = 1'b1;
        do_tick();
        attack = 1'b0; left = 1'b0;
        lit("buf_set", int'(buffered), 1);
        do_tick();
        lit("buf_still_rec", int'(state), 5);
        do_tick();
        lit("buf_to_dir_start", int'(state), 6);
        lit("buf_cleared", int'(buffered), 0);

        // press at recovery frame 12 is outside the window
        settle();
        atk_to_rec(12);
        attack = 1'b1;
        do_tick();
        attack = 1'b0;
        lit("buf_early_ignored", int'(buffered), 0);
        repeat (3) do_tick();
        lit("rec_exit_idle", int'(state), 0);

        // freeze without ticks, then asynchronous reset
        settle();
        attack = 1'b1;
        repeat (2) do_tick();
        got_hit = 1'b1; attack = 1'b0;
        repeat (50) @(negedge clk);
        attack = 1'b1;
        repeat (50) @(negedge clk);
        #1;
        got_hit = 1'b0;
        lit("freeze_state", int'(state), 3);
        lit("freeze_counter", int'(frame_counter), 1);
        #2 reset = 1'b1;
        #1;
        lit("async_rst_state", int'(state), 0);
        lit("async_rst_flags", int'({move_flag, attack_flag, directional_attack_flag,
                                     hitbox_active, stunned, buffered}), 0);
        @(negedge clk); #1;
        reset = 1'b0;
        do_tick();
        lit("post_rst_press", int'(state), 3);

        // blockstun restarted at frame 5 runs the full 13 again
        settle();
        got_blocked = 1'b1; src_dir = 1'b0;
        do_tick();
        repeat (5) do_tick();
        lit("blk_frame5", int'(frame_counter), 5);
        got_blocked = 1'b1;
        do_tick();
        lit("blk_restart_cnt", int'(frame_counter), 0);
        lit("blk_restart_state", int'(state), 10);
        n = stunned ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            do_tick();
            if (stunned) n++;
        end
        lit("blockstun_len", n, 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
